add16_nibble_seq: RTL and testbench
===================================

ADD16_NIBBLE_SEQ -- requirements
Module: add16_nibble_seq

Interface
REQ-001 SHALL have parameter NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request to begin an operation; sampled on rising clk.
REQ-006 a  input  W  operand A, captured on an accepted start.
REQ-007 b  input  W  operand B, captured on an accepted start.
REQ-008 cin  input  1  carry-in, captured on an accepted start.
REQ-009 op  input  1  0 = add, 1 = subtract; present only with SUB16_EN (REQ-028).
REQ-010 busy  output  1  high while nibbles are being processed.
REQ-011 done  output  1  one-cycle pulse when the result is complete.
REQ-012 sum  output  W  result, written one nibble per cycle.
REQ-013 cout  output  1  carry-out of the most significant nibble.

Function
REQ-014 SHALL compute {cout,sum} = a + b + cin using one shared 4-bit add stage, one nibble per cycle, least significant nibble first.
REQ-015 SHALL implement an FSM with three states:
- IDLE: wait for start.
- RUN: process nibbles.
- DONE: present the result.
REQ-016 SHALL, in IDLE or DONE with start=1 at a rising edge:
- capture a, b and cin (the carry register is loaded with cin);
- clear the nibble index to 0;
- clear sum and cout;
- enter RUN.
REQ-017 SHALL, on each rising edge in RUN:
- add nibble[idx] of A, nibble[idx] of B and the carry register;
- write the 4-bit result to sum[4*idx+3:4*idx];
- update the carry register;
- increment idx.
REQ-018 SHALL, on the rising edge that processes idx = NIBBLES-1, load cout from the final carry and move to DONE.
REQ-019 Latency: if start is accepted at edge 0, nibbles are processed at edges 1..NIBBLES, and done is high for exactly the cycle following edge NIBBLES.
REQ-020 busy SHALL be high exactly while the state is RUN; done SHALL be high exactly while the state is DONE.
REQ-021 DONE SHALL return to IDLE on the next edge when start=0; a start in DONE SHALL begin a new operation directly (REQ-016).
REQ-022 start while in RUN SHALL be ignored; captured operands SHALL NOT change during RUN.
REQ-023 sum and cout SHALL hold their last values in IDLE until the next accepted start.
REQ-024 Input changes on a, b or cin outside an accepted start SHALL have no effect.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-RUN, immediately set:
- state to IDLE;
- busy, done, cout to 0;
- sum to 0;
- idx to 0;
- the carry register to 0.
REQ-026 SHALL resume normal operation on the first rising edge after rst_n is released; an aborted operation SHALL NOT produce done.

Configuration
REQ-027 Macro SUB16_EN SHALL gate subtract support.
REQ-028 With SUB16_EN defined:
- port op exists;
- op=1 at the accepted start captures ~b and forces the carry register to 1 (cin is ignored), giving sum = a - b, with cout = 1 meaning no borrow;
- op=0 behaves as add.
REQ-029 Without SUB16_EN: port op is absent and the block performs add only.

Verification
REQ-030 a=0x1234, b=0x4321, cin=0, start pulse -> done high 4 cycles after the start edge, sum=0x5555, cout=0; busy high for 4 cycles.
REQ-031 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1 (carry ripples through all nibbles); a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
REQ-032 start re-asserted with a=0x0001 during RUN of 0x1234+0x4321 -> ignored; result still 0x5555 with a single done pulse.
REQ-033 rst_n pulsed low after 2 RUN cycles -> busy, done, sum and cout read 0 immediately; no done follows; next start with 0x0F0F+0x0101 gives 0x1010.
REQ-034 start held high through DONE -> back-to-back operations, each with a one-cycle done, 5 cycles apart.
REQ-035 SUB16_EN defined: op=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; op=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/add16_nibble_seq.sv
// Nibble-serial adder: one shared 4-bit add stage, LS nibble first, IDLE/RUN/DONE FSM.
// Optional subtract support (op port, a - b) is enabled by defining SUB16_EN.
module add16_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
`ifdef SUB16_EN
  input  logic                 op,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_sum;
  logic             r_cout;

  logic             w_accept;
  logic             w_last;
  logic [W-1:0]     w_b_in;
  logic             w_cin_in;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [4:0]       w_nib_sum;

  // Subtraction is a + ~b + 1, so only the captured B and carry differ.
`ifdef SUB16_EN
  assign w_b_in   = op ? ~b   : b;
  assign w_cin_in = op ? 1'b1 : cin;
`else
  assign w_b_in   = b;
  assign w_cin_in = cin;
`endif

  assign w_accept  = start && (r_state != S_RUN);
  assign w_last    = (r_idx == IDX_W'(NIBBLES - 1));
  assign w_a_nib   = r_a[4*r_idx +: 4];
  assign w_b_nib   = r_b[4*r_idx +: 4];
  assign w_nib_sum = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, r_carry};

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: w_state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: every datapath register is async-reset so an aborted operation
  // leaves no stale carry, index or partial sum behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= w_b_in;
      r_carry <= w_cin_in;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == S_RUN) begin
      r_sum[4*r_idx +: 4] <= w_nib_sum[3:0];
      r_carry             <= w_nib_sum[4];
      r_idx               <= r_idx + IDX_W'(1);
      if (w_last) r_cout <= w_nib_sum[4];
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_add16_nibble_seq.sv
// Self-checking bench for add16_nibble_seq: directed cases plus randomized ops
// against an arithmetic reference model. Define SUB16_EN to cover subtraction.
module tb_add16_nibble_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;
  localparam int PER = 10;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int           n_checks;
  int           n_fail;
  logic [W-1:0] last_sum;
  logic         last_cout;
  time          t_done;
  time          t_prev;

  add16_nibble_seq #(.NIBBLES(NIB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SUB16_EN
    .op    (op),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #(PER/2) clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands as presented at start.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mcin,
                       input logic mop, output logic [W-1:0] es, output logic ec);
    logic [W:0] full;
    full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
    es   = full[W-1:0];
    ec   = full[W];
`ifdef SUB16_EN
    if (mop) begin
      es = ma - mb;
      ec = (ma >= mb);
    end
`endif
  endtask

  // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge
  // where done should be high. hold keeps start asserted throughout.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                       input logic oop, input logic hold);
    logic [W-1:0] es;
    logic         ec;
    model(oa, ob, ocin, oop, es, ec);
    start = 1'b1;
    a = oa; b = ob; cin = ocin; op = oop;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    op  = 1'($urandom);
    for (int k = 0; k < NIB; k++) begin
      check("run_busy", 32'(busy), 32'd1);
      check("run_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    t_prev = t_done;
    t_done = $time;
    check("done_pulse", 32'(done), 32'd1);
    check("done_busy",  32'(busy), 32'd0);
    check("sum",        32'(sum),  32'(es));
    check("cout",       32'(cout), 32'(ec));
    last_sum  = es;
    last_cout = ec;
  endtask

  // One idle cycle: done must drop and results must hold despite input noise.
  task automatic idle_check();
    start = 1'b0;
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    @(negedge clk);
    check("idle_done", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_sum",  32'(sum),  32'(last_sum));
    check("idle_cout", 32'(cout), 32'(last_cout));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    t_done   = 0;
    t_prev   = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0; op = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add with known answer and latency.
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    check("k_5555", 32'(sum), 32'h5555);
    idle_check();
    idle_check();

    // Full-width carry ripple.
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    check("k_ripple_sum",  32'(sum),  32'h0000);
    check("k_ripple_cout", 32'(cout), 32'd1);
    idle_check();
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    check("k_ffff_sum",  32'(sum),  32'hFFFF);
    check("k_ffff_cout", 32'(cout), 32'd1);
    idle_check();

    // start held during RUN is ignored; only one done pulse follows.
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1);
    check("k_ign_sum", 32'(sum), 32'h5555);
    idle_check();

    // Abort mid-RUN with reset.
    start = 1'b1;
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; op = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 16'h0001;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < NIB + 2; k++) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_no_busy", 32'(busy), 32'd0);
    end
    do_op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b0);
    check("k_1010", 32'(sum), 32'h1010);
    idle_check();

    // Back-to-back with start held through DONE.
    do_op(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1);
    do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b1);
    check("b2b_gap", 32'(t_done - t_prev), 32'((NIB + 1) * PER));
    do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
    check("b2b_gap", 32'(t_done - t_prev), 32'((NIB + 1) * PER));
    idle_check();

`ifdef SUB16_EN
    do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0);
    check("k_sub_neg_sum",  32'(sum),  32'hFFFE);
    check("k_sub_neg_cout", 32'(cout), 32'd0);
    idle_check();
    do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b0);
    check("k_sub_pos_sum",  32'(sum),  32'h0002);
    check("k_sub_pos_cout", 32'(cout), 32'd1);
    idle_check();
`endif

    // Randomized operations, mixing idle gaps and back-to-back starts.
    for (int i = 0; i < 24; i++) begin
      logic hold;
      logic rop;
      hold = 1'($urandom);
`ifdef SUB16_EN
      rop = 1'($urandom);
`else
      rop = 1'b0;
`endif
      do_op(W'($urandom), W'($urandom), 1'($urandom), rop, hold);
      if (!hold) idle_check();
    end
    idle_check();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
